// File: rtl/wt_pack_writer.sv
// Weight pack writer: turns a DDR byte stream of 3x3/5x5 kernels (8-bit or 4-bit packed)
// into one 200-bit PE_weight_t word per kernel and writes it into the weight buffer.

module wt_pack_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);
  // q_nxt lets the final beat's weight reach the write word in the same edge it is captured
  always_comb begin
    q_nxt = q;
    if (clr)     q_nxt = '0;
    else if (ld) q_nxt = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end
endmodule

module wt_pack_writer #(
  parameter int BIT_WIDTH           = 8,
  parameter int CONF_DDR_DATA_WIDTH = 8,
  parameter int CONF_WT_BUF_DEPTH   = 512,
  parameter int AW                  = $clog2(CONF_WT_BUF_DEPTH),
  parameter int NUM_LANES           = 25,
  parameter int WORD_W              = NUM_LANES * BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           kernel_mode,
  input  logic                           bit_mode,
  input  logic [AW:0]                    kernel_num,
  input  logic [AW-1:0]                  base_addr,
  input  logic [CONF_DDR_DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           wt_wr_en,
  output logic [AW-1:0]                  wt_wr_addr,
  output logic [WORD_W-1:0]              wt_wr_data,
  output logic                           busy,
  output logic                           done
);
  localparam int CW = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  typedef struct packed {
    logic [8:0][BIT_WIDTH-1:0] a_9;
    logic [5:0][BIT_WIDTH-1:0] b_6;
    logic [5:0][BIT_WIDTH-1:0] c_6;
    logic [3:0][BIT_WIDTH-1:0] d_4;
  } pe_weight_t;

  state_t        state;
  logic          km_r, bm_r;
  logic [AW:0]   knum_r, kidx;
  logic [AW-1:0] base_r;
  logic [CW-1:0] wt_cnt, n_wt, step;
  logic          beat, last_beat, pack_clr;
  logic [BIT_WIDTH-1:0] w0, w1;
  logic [NUM_LANES-1:0]                lane_ld;
  logic [NUM_LANES-1:0][BIT_WIDTH-1:0] lane_d, lane_q, lane_q_nxt;
  pe_weight_t    word_nxt;

  assign n_wt      = km_r ? CW'(25) : CW'(9);
  assign step      = bm_r ? CW'(2) : CW'(1);
  assign beat      = (state == RECV) && in_valid && in_ready;
  assign last_beat = beat && ((wt_cnt + step) >= n_wt);
  assign pack_clr  = ((state == IDLE) && start) || (state == WRITE);

  // 4-bit mode: low nibble is weight k, high nibble weight k+1, both sign-extended
  assign w0 = bm_r ? {{(BIT_WIDTH-4){in_data[3]}}, in_data[3:0]} : in_data[BIT_WIDTH-1:0];
  assign w1 = {{(BIT_WIDTH-4){in_data[7]}}, in_data[7:4]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic sel0, sel1;
    assign sel0       = (wt_cnt == CW'(i));
    assign sel1       = bm_r && ((wt_cnt + CW'(1)) == CW'(i)) && (CW'(i) < n_wt);
    assign lane_ld[i] = beat && (sel0 || sel1);
    assign lane_d[i]  = sel0 ? w0 : w1;

    wt_pack_lane #(.W(BIT_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (pack_clr),
      .ld    (lane_ld[i]),
      .d     (lane_d[i]),
      .q     (lane_q[i]),
      .q_nxt (lane_q_nxt[i])
    );
  end

  // Row-major kernel index k maps A_9[0..8], B_6[0..5], C_6[0..5], D_4[0..3]
  always_comb begin
    word_nxt = '0;
    for (int j = 0; j < 9; j++) word_nxt.a_9[j] = lane_q_nxt[j];
    for (int j = 0; j < 6; j++) word_nxt.b_6[j] = lane_q_nxt[9 + j];
    for (int j = 0; j < 6; j++) word_nxt.c_6[j] = lane_q_nxt[15 + j];
    for (int j = 0; j < 4; j++) word_nxt.d_4[j] = lane_q_nxt[21 + j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      km_r       <= 1'b0;
      bm_r       <= 1'b0;
      knum_r     <= '0;
      base_r     <= '0;
      kidx       <= '0;
      wt_cnt     <= '0;
      in_ready   <= 1'b0;
      wt_wr_en   <= 1'b0;
      wt_wr_addr <= '0;
      wt_wr_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wt_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          km_r   <= kernel_mode;
          bm_r   <= bit_mode;
          knum_r <= kernel_num;
          base_r <= base_addr;
          kidx   <= '0;
          wt_cnt <= '0;
          if (kernel_num == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= RECV;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RECV: if (beat) begin
          if (last_beat) begin
            state      <= WRITE;
            in_ready   <= 1'b0;
            wt_wr_en   <= 1'b1;
            wt_wr_data <= word_nxt;
            wt_wr_addr <= base_r + kidx[AW-1:0];
            wt_cnt     <= '0;
          end else begin
            wt_cnt <= wt_cnt + step;
          end
        end
        WRITE: begin
          kidx <= kidx + (AW+1)'(1);
          if ((kidx + (AW+1)'(1)) == knum_r) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= RECV;
            in_ready <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
